// File: rtl/ddr_rx_deser.sv
// DDR receive deserializer: double-edge pin capture, aligned pair pipeline, word assembly with bitslip.
// Optional parity on o_perr is built only when DDR_RX_DESER_PARITY_EN is defined.
module ddr_rx_deser #(
   parameter string DDR_CLK_EDGE  = "SAME_EDGE_PIPELINED",
   parameter logic  INIT_Q1       = 1'b0,
   parameter logic  INIT_Q2       = 1'b0,
   parameter logic  IS_D_INVERTED = 1'b0,
   parameter int    WORD_W        = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_ce,
   input  logic              i_d,
   input  logic              i_bitslip,
   output logic              o_q1,
   output logic              o_q2,
   output logic [WORD_W-1:0] o_word,
   output logic              o_valid,
   output logic              o_perr
);

   localparam int PAIRS = WORD_W / 2;
   localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAIRS - 1);
   localparam bit MODE_OPP  = (DDR_CLK_EDGE == "OPPOSITE_EDGE");
   localparam bit MODE_SAME = (DDR_CLK_EDGE == "SAME_EDGE");

   logic              d_s;
   logic              rise_r;
   logic              fall_r;
   logic              pipe_rise_r;
   logic              pipe_fall_r;
   // H[1:0] are never read after the shift, so only H[WORD_W:2] is kept as state
   logic [WORD_W:2]   hist_r;
   logic [WORD_W:0]   hist_next_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_next_s;
   logic              phase_r;
   logic              wrap_s;
   logic              hold_s;
   logic [WORD_W-1:0] word_next_s;
   logic [WORD_W-1:0] word_r;
   logic              valid_r;

   assign d_s         = i_d ^ IS_D_INVERTED;
   assign hist_next_s = {pipe_fall_r, pipe_rise_r, hist_r[WORD_W:2]};
   assign wrap_s      = (cnt_r == CNT_LAST);
   assign hold_s      = i_bitslip & ~phase_r;

   // Falling-edge capture of the pin.
   always_ff @(negedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fall_r <= INIT_Q2;
      end else if (i_ce) begin
         fall_r <= d_s;
      end
   end

   // Next counter value and the word window selected by the current phase.
   always_comb begin
      cnt_next_s  = cnt_r;
      word_next_s = hist_next_s[WORD_W:1];
      if (hold_s) begin
         cnt_next_s = cnt_r;
      end else if (wrap_s) begin
         cnt_next_s = {CNT_W{1'b0}};
      end else begin
         cnt_next_s = cnt_r + CNT_W'(1);
      end
      if (phase_r) begin
         word_next_s = hist_next_s[WORD_W-1:0];
      end else begin
         word_next_s = hist_next_s[WORD_W:1];
      end
   end

   // Rising-edge capture, aligned pair pipeline, history shift, counter, phase and word output.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rise_r      <= INIT_Q1;
         pipe_rise_r <= INIT_Q1;
         pipe_fall_r <= INIT_Q2;
         hist_r      <= {(WORD_W-1){1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         phase_r     <= 1'b0;
         word_r      <= {WORD_W{1'b0}};
         valid_r     <= 1'b0;
      end else if (i_ce) begin
         rise_r      <= d_s;
         pipe_rise_r <= rise_r;
         pipe_fall_r <= fall_r;
         hist_r      <= hist_next_s[WORD_W:2];
         cnt_r       <= cnt_next_s;
         phase_r     <= phase_r ^ i_bitslip;
         valid_r     <= wrap_s;
         if (wrap_s) begin
            word_r <= word_next_s;
         end
      end else begin
         valid_r <= 1'b0;
      end
   end

   // Pin-side view depends on capture mode; the deserializer always uses the aligned pair.
   generate
      if (MODE_OPP) begin : g_opp
         assign o_q1 = rise_r;
         assign o_q2 = fall_r;
      end else if (MODE_SAME) begin : g_same
         assign o_q1 = rise_r;
         assign o_q2 = pipe_fall_r;
      end else begin : g_pipe
         assign o_q1 = pipe_rise_r;
         assign o_q2 = pipe_fall_r;
      end
   endgenerate

   assign o_word  = word_r;
   assign o_valid = valid_r;

`ifdef DDR_RX_DESER_PARITY_EN
   logic perr_r;

   function automatic logic odd_parity(input logic [WORD_W-1:0] w);
      odd_parity = ^w;
   endfunction

   // Parity flag registered together with the word strobe.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         perr_r <= 1'b0;
      end else if (i_ce && wrap_s) begin
         perr_r <= odd_parity(word_next_s);
      end else begin
         perr_r <= 1'b0;
      end
   end

   assign o_perr = perr_r;
`else
   assign o_perr = 1'b0;
`endif

endmodule

// File: doc/ddr_rx_deser.md
DDR_RX_DESER -- requirements
Module: ddr_rx_deser

Interface
REQ-001 The block SHALL have parameter DDR_CLK_EDGE, default "SAME_EDGE_PIPELINED", meaning the pin-side capture mode; legal values are "OPPOSITE_EDGE", "SAME_EDGE" and "SAME_EDGE_PIPELINED".
REQ-002 The block SHALL have parameter INIT_Q1, default 1'b0, meaning the reset value of o_q1.
REQ-003 The block SHALL have parameter INIT_Q2, default 1'b0, meaning the reset value of o_q2.
REQ-004 The block SHALL have parameter IS_D_INVERTED, default 1'b0; when it is 1, i_d is inverted before capture.
REQ-005 The block SHALL have parameter WORD_W, default 8, meaning the deserialized word width; legal values are even numbers from 4 to 16.
REQ-006 The block SHALL have port i_clk, input, width 1: the single clock; both edges are used.
REQ-007 The block SHALL have port i_rst_n, input, width 1: reset, asynchronous and active-low.
REQ-008 The block SHALL have port i_ce, input, width 1: clock enable for all state.
REQ-009 The block SHALL have port i_d, input, width 1: the DDR serial data pin.
REQ-010 The block SHALL have port i_bitslip, input, width 1: single-cycle request to shift the word boundary.
REQ-011 The block SHALL have ports o_q1 and o_q2, output, width 1 each: the captured rise bit and fall bit.
REQ-012 The block SHALL have port o_word, output, width WORD_W: the deserialized word, oldest bit at the LSB.
REQ-013 The block SHALL have port o_valid, output, width 1: a one-cycle strobe marking o_word as new.
REQ-014 The block SHALL have port o_perr, output, width 1: parity error, qualified by o_valid.

Function
REQ-015 With i_ce=1, d = i_d ^ IS_D_INVERTED SHALL be sampled at every rising edge (R(t)) and every falling edge (F(t), the falling edge after rising edge t).
REQ-016 In OPPOSITE_EDGE mode, o_q1 SHALL update to R(t) at rising edge t, and o_q2 SHALL update to F(t) at the following falling edge.
REQ-017 In SAME_EDGE mode, at rising edge t+1 o_q1 SHALL become R(t+1) and o_q2 SHALL become F(t), with both updating only on the rising edge.
REQ-018 In SAME_EDGE_PIPELINED mode, at rising edge t+1 o_q1 SHALL become R(t) and o_q2 SHALL become F(t), so the pair arrives aligned with one cycle of latency.
REQ-019 The deserializer SHALL always consume the aligned pair {R(t), F(t)}, independent of DDR_CLK_EDGE.
REQ-020 At rising edge t+2 the pair SHALL be shifted into a history register H[WORD_W:0] with F(t) at H[WORD_W] and R(t) at H[WORD_W-1].
REQ-021 A pair counter running 0..WORD_W/2-1 SHALL increment on each pair shift and wrap to 0.
REQ-022 On the edge where the counter wraps, o_word SHALL be registered and o_valid SHALL be 1 for exactly the following cycle; o_valid SHALL be 0 in all other cycles.
REQ-023 The phase bit SHALL select the word window: o_word = H[WORD_W:1] when phase=0, and o_word = H[WORD_W-1:0] when phase=1.
REQ-024 When i_bitslip=1 and i_ce=1, phase SHALL toggle; on a 0->1 toggle the pair counter SHALL also hold for that cycle. Each slip moves the word boundary one bit later in the stream, and WORD_W slips restore the original alignment.
REQ-025 A bitslip that coincides with a counter wrap SHALL still emit the word with the old phase; the new phase applies from the next word.
REQ-026 When i_ce=0, all registers SHALL hold, o_valid SHALL be 0, and i_bitslip SHALL be ignored.

Reset
REQ-027 On assertion of i_rst_n=0, immediately and regardless of the clock: o_q1=INIT_Q1, o_q2=INIT_Q2, H=0, counter=0, phase=0, o_word=0, o_valid=0 and o_perr=0.
REQ-028 After reset deasserts, the first o_valid SHALL follow the WORD_W/2-th pair shift; a reset asserted mid-word SHALL discard the partial word.

Configuration
REQ-029 With macro DDR_RX_DESER_PARITY_EN defined, o_perr SHALL equal the XOR-reduction of the registered o_word (odd count of ones = error), registered alongside o_valid.
REQ-030 Without DDR_RX_DESER_PARITY_EN, o_perr SHALL be constant 0 and no parity logic SHALL be built.

Verification
REQ-031 SAME_EDGE_PIPELINED, WORD_W=8, i_d drives 8'hA5 LSB-first, rise bit first -> o_valid is a single cycle, o_word=8'hA5, o_perr=0.
REQ-032 OPPOSITE_EDGE, i_d=1 on rise and 0 on fall -> o_q1=1 after the rising edge and o_q2=0 after the falling edge in the same cycle.
REQ-033 Continuous stream of 8'h3C with a single bitslip pulse -> words after the slip equal 8'h3C rotated by one bit; 8 slips restore 8'h3C.
REQ-034 i_ce=0 for 5 cycles mid-word -> no o_valid during the gap, and the word completes correctly after i_ce returns to 1.
REQ-035 INIT_Q1=1, INIT_Q2=1, i_rst_n pulsed low between clock edges -> o_q1=o_q2=1 and o_valid=0 immediately, before the next edge.
REQ-036 With DDR_RX_DESER_PARITY_EN, stream 8'h01 -> o_perr=1 with o_valid; without the macro, the same stream -> o_perr=0.
